// File: rtl/filter_pkg.sv
// Shared definitions for the CA4 filter path: loader state encoding, default
// scratchpad geometry and the address-width helper also used by the filter
// address generator.
package filter_pkg;

    localparam int DEFAULT_HEIGHT = 16;
    localparam int DEFAULT_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } filter_state_t;

    // Address bits needed to index a scratchpad of the given depth (min 1).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/filter_spad.sv
// Filter scratchpad: HEIGHT x WIDTH storage with one synchronous write port
// and one registered read port. A read and a write to the same address in
// the same cycle return the previous contents. Storage is not reset; only
// the read register is.
module filter_spad
    import filter_pkg::*;
#(
    parameter int HEIGHT    = DEFAULT_HEIGHT,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADD_WIDTH = addr_width(HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADD_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADD_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [HEIGHT];

    // Write port: store the accepted word at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered read, one cycle of latency, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/filter_loader.sv
// Filter loader: accepts filter words over a valid/ready handshake, writes
// them into a circular scratchpad, counts resident complete filters and
// frees one filter's worth of space per release from the address generator.
// The release input is named filter_release because "release" is a reserved
// word in SystemVerilog.
// Optional: define FILTER_LOADER_ERR_EN to add a sticky err output flagging
// releases with no resident filter and ignored/invalid start pulses.
module filter_loader
    import filter_pkg::*;
#(
    parameter int HEIGHT    = DEFAULT_HEIGHT,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADD_WIDTH = addr_width(HEIGHT),
    parameter int NUM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADD_WIDTH:0]   filter_size,
    input  logic [NUM_WIDTH-1:0] num_filters,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 filter_release,
    input  logic [ADD_WIDTH-1:0] filter_raddr,
    output logic [WIDTH-1:0]     filter_rdata,
    output logic                 filter_avail,
    output logic                 load_done,
    output logic                 busy
`ifdef FILTER_LOADER_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam logic [ADD_WIDTH:0] HEIGHT_W = (ADD_WIDTH + 1)'(HEIGHT);

    filter_state_t        state;
    logic [ADD_WIDTH:0]   fs;
    logic [NUM_WIDTH-1:0] nf;
    logic [ADD_WIDTH-1:0] wptr;
    logic [ADD_WIDTH:0]   words_stored;
    logic [ADD_WIDTH:0]   filter_word_cnt;
    logic [ADD_WIDTH:0]   filter_count;
    logic [NUM_WIDTH-1:0] loaded_cnt;

    logic                 start_ok;
    logic                 xfer;
    logic                 word_last;
    logic                 fill;
    logic                 rel_ok;
    logic [ADD_WIDTH:0]   count_next;
    logic [ADD_WIDTH:0]   ws_next;

    // Handshake, filter-completion and occupancy arithmetic for this cycle.
    always_comb begin
        start_ok  = (filter_size != '0) && (filter_size <= HEIGHT_W) &&
                    (num_filters != '0);
        in_ready  = (state == LOAD) && (words_stored < HEIGHT_W) &&
                    (loaded_cnt < nf);
        xfer      = in_valid && in_ready;
        word_last = (filter_word_cnt == (fs - 1'b1));
        fill      = xfer && word_last;
        rel_ok    = filter_release && (filter_count != '0);

        // A fill and a release in the same cycle cancel in the filter count.
        count_next = filter_count;
        if (fill && !rel_ok) begin
            count_next = filter_count + 1'b1;
        end else if (!fill && rel_ok) begin
            count_next = filter_count - 1'b1;
        end

        ws_next = words_stored + {{ADD_WIDTH{1'b0}}, xfer} - (rel_ok ? fs : '0);
    end

    // Control FSM with pointers, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            fs              <= '0;
            nf              <= '0;
            wptr            <= '0;
            words_stored    <= '0;
            filter_word_cnt <= '0;
            filter_count    <= '0;
            loaded_cnt      <= '0;
            filter_avail    <= 1'b0;
            load_done       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            words_stored <= ws_next;
            filter_count <= count_next;
            filter_avail <= (count_next != '0);

            if (xfer) begin
                wptr            <= wptr + 1'b1;
                filter_word_cnt <= word_last ? '0 : filter_word_cnt + 1'b1;
            end
            if (fill) begin
                loaded_cnt <= loaded_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start && start_ok) begin
                        state           <= LOAD;
                        busy            <= 1'b1;
                        load_done       <= 1'b0;
                        fs              <= filter_size;
                        nf              <= num_filters;
                        wptr            <= '0;
                        words_stored    <= '0;
                        filter_word_cnt <= '0;
                        filter_count    <= '0;
                        loaded_cnt      <= '0;
                        filter_avail    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (fill && ((loaded_cnt + 1'b1) == nf)) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (filter_count == '0) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        load_done <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    load_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef FILTER_LOADER_ERR_EN
    // Sticky error flag for ignored releases and ignored or invalid starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((filter_release && (filter_count == '0)) ||
                     (start && (state != IDLE)) ||
                     (start && (state == IDLE) && !start_ok)) begin
            err <= 1'b1;
        end
    end
`endif

    filter_spad #(
        .HEIGHT    (HEIGHT),
        .WIDTH     (WIDTH),
        .ADD_WIDTH (ADD_WIDTH)
    ) u_spad (
        .clk   (clk),
        .rst   (rst),
        .wr_en (xfer),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (filter_raddr),
        .rdata (filter_rdata)
    );

endmodule

// File: tb/tb_filter_loader.sv
// Bench for filter_loader: a count-based reference model runs in lock-step
// with the DUT and is compared every cycle, alongside a start-validity table
// and directed sequences for load, backpressure, wrap-around, simultaneous
// fill/release and mid-load reset.
module tb_filter_loader;

    localparam int H  = 16;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   filter_size = '0;
    logic [NW-1:0] num_filters = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          filter_release = 1'b0;
    logic [AW-1:0] filter_raddr = '0;
    logic [W-1:0]  filter_rdata;
    logic          filter_avail;
    logic          load_done;
    logic          busy;
`ifdef FILTER_LOADER_ERR_EN
    logic          err;
`endif

    filter_loader #(.HEIGHT(H), .WIDTH(W), .ADD_WIDTH(AW), .NUM_WIDTH(NW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .filter_size    (filter_size),
        .num_filters    (num_filters),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .filter_release (filter_release),
        .filter_raddr   (filter_raddr),
        .filter_rdata   (filter_rdata),
        .filter_avail   (filter_avail),
        .load_done      (load_done),
        .busy           (busy)
`ifdef FILTER_LOADER_ERR_EN
        ,
        .err            (err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a run is described by how many words were written
    // and how many filters were released; everything else is derived.
    bit           m_busy, m_done, m_err;
    int           m_fs = 1, m_nf = 0, m_written = 0, m_released = 0;
    logic [W-1:0] m_mem [H];
    bit           m_known [H];
    logic [W-1:0] m_rdata;
    bit           m_rdata_known;

    function automatic int m_completed();
        return m_written / m_fs;
    endfunction
    function automatic int m_fc();
        return m_completed() - m_released;
    endfunction
    function automatic int m_ws();
        return m_written - m_released * m_fs;
    endfunction
    function automatic bit m_ready();
        return m_busy && !m_done && (m_ws() < H) && (m_completed() < m_nf);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0;
        m_fs = 1; m_nf = 0; m_written = 0; m_released = 0;
        m_rdata = '0; m_rdata_known = 1;
    endtask

    task automatic model_step();
        int  fc;
        bit  xfer, sv;
        if (!rst) begin
            model_reset();
            return;
        end
        fc   = m_fc();
        xfer = in_valid && m_ready();
        sv   = (filter_size >= 1) && (filter_size <= H) && (num_filters != 0);
        if ((filter_release && fc == 0) || (start && m_busy) || (start && !m_busy && !sv))
            m_err = 1;
        m_rdata_known = m_known[filter_raddr];
        m_rdata       = m_mem[filter_raddr];
        if (xfer) begin
            m_mem[m_written % H]   = in_data;
            m_known[m_written % H] = 1;
            m_written++;
        end
        if (filter_release && fc != 0) m_released++;
        if (!m_busy) begin
            if (start && sv) begin
                m_busy = 1; m_done = 0;
                m_fs = int'(filter_size); m_nf = int'(num_filters);
                m_written = 0; m_released = 0;
            end
        end else if (!m_done) begin
            if (xfer && (m_written % m_fs == 0) && (m_written / m_fs == m_nf)) m_done = 1;
        end else if (fc == 0) begin
            m_busy = 0; m_done = 0;
        end
    endtask

    task automatic check_model();
        check("in_ready", in_ready, m_ready());
        check("filter_avail", filter_avail, m_fc() != 0);
        check("load_done", load_done, m_done);
        check("busy", busy, m_busy);
        if (m_rdata_known) check("filter_rdata", filter_rdata, m_rdata);
`ifdef FILTER_LOADER_ERR_EN
        check("err", err, m_err);
`endif
    endtask

    // One clock: model steps on the rising edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic apply_reset();
        rst = 0; start = 0; in_valid = 0; filter_release = 0;
        #1;
        model_reset();
        check("rst_in_ready", in_ready, 0);
        check("rst_filter_avail", filter_avail, 0);
        check("rst_load_done", load_done, 0);
        check("rst_busy", busy, 0);
        check("rst_filter_rdata", filter_rdata, 0);
        cycle();
        rst = 1;
    endtask

    task automatic do_start(input int fs, input int nf);
        filter_size = AW'(0) + fs[AW:0];
        num_filters = nf[NW-1:0];
        start = 1;
        cycle();
        start = 0;
    endtask

    task automatic push(input logic [W-1:0] d);
        int guard = 0;
        in_valid = 1;
        in_data  = d;
        while (!in_ready && guard < 50) begin
            cycle();
            guard++;
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
        end
        cycle();
        in_valid = 0;
    endtask

    task automatic pulse_release();
        filter_release = 1;
        cycle();
        filter_release = 0;
    endtask

    typedef struct {
        int fs;
        int nf;
        bit exp_busy;
    } start_vec_t;

    start_vec_t tbl [7];

    initial begin
        int acc, k, guard;

        tbl[0] = '{0, 1, 0};
        tbl[1] = '{1, 1, 1};
        tbl[2] = '{16, 1, 1};
        tbl[3] = '{17, 1, 0};
        tbl[4] = '{4, 0, 0};
        tbl[5] = '{31, 5, 0};
        tbl[6] = '{8, 255, 1};
        for (int i = 0; i < H; i++) m_known[i] = 0;

        @(negedge clk);

        // Start-validity table.
        for (int i = 0; i < 7; i++) begin
            apply_reset();
            do_start(tbl[i].fs, tbl[i].nf);
            check("tbl_busy", busy, tbl[i].exp_busy);
            check("tbl_in_ready", in_ready, tbl[i].exp_busy);
        end

        // Basic load: fs=4, nf=2, words 0x10..0x17.
        apply_reset();
        do_start(4, 2);
        for (int i = 0; i < 8; i++) begin
            push(8'h10 + 8'(i));
            if (i == 2) check("basic_avail_early", filter_avail, 0);
            if (i == 3) check("basic_avail", filter_avail, 1);
            if (i == 6) check("basic_done_early", load_done, 0);
        end
        check("basic_done", load_done, 1);
        check("basic_words_stored", dut.words_stored, 8);
        for (int a = 0; a < 8; a++) begin
            filter_raddr = AW'(a);
            cycle();
            check("basic_read", filter_rdata, 8'h10 + 8'(a));
        end

        // Backpressure: fs=8, nf=3, no release until the pad is full.
        apply_reset();
        do_start(8, 3);
        in_valid = 1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'($urandom);
            if (in_ready) acc++;
            cycle();
        end
        check("bp_accepted_full", acc, 16);
        check("bp_ready_low", in_ready, 0);
        pulse_release();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'($urandom);
            if (in_ready) acc++;
            cycle();
        end
        in_valid = 0;
        check("bp_accepted_more", acc, 8);
        check("bp_done", load_done, 1);

        // Wrap-around: fs=6, nf=4, release whenever a filter is resident.
        apply_reset();
        do_start(6, 4);
        in_valid = 1;
        k = 0;
        guard = 0;
        while (!load_done && guard < 200) begin
            in_data = 8'h40 + 8'(k);
            filter_release = filter_avail;
            if (in_ready) k++;
            cycle();
            guard++;
        end
        in_valid = 0;
        filter_release = 0;
        check("wrap_done", load_done, 1);
        check("wrap_words", k, 24);
        filter_raddr = 4'd0;
        cycle();
        check("wrap_read0", filter_rdata, 8'h50);
        filter_raddr = 4'd1;
        cycle();
        check("wrap_read1", filter_rdata, 8'h51);
        filter_raddr = 4'd12;
        cycle();
        check("wrap_read12", filter_rdata, 8'h4C);

        // Release in the same cycle as a filter-completing write.
        apply_reset();
        do_start(4, 3);
        for (int i = 0; i < 7; i++) push(8'h20 + 8'(i));
        check("sim_ready", in_ready, 1);
        in_valid = 1;
        in_data = 8'h27;
        filter_release = 1;
        cycle();
        in_valid = 0;
        filter_release = 0;
        check("sim_filter_count", dut.filter_count, 1);
        check("sim_words_stored", dut.words_stored, 4);
        check("sim_avail", filter_avail, 1);

        // Reset in the middle of a load, then a fresh small load.
        apply_reset();
        do_start(4, 3);
        for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
        check("mid_busy", busy, 1);
        apply_reset();
        do_start(2, 1);
        push(8'hA0);
        push(8'hA1);
        check("fresh_done", load_done, 1);
        filter_raddr = 4'd0;
        cycle();
        check("fresh_read0", filter_rdata, 8'hA0);
        filter_raddr = 4'd1;
        cycle();
        check("fresh_read1", filter_rdata, 8'hA1);

`ifdef FILTER_LOADER_ERR_EN
        apply_reset();
        pulse_release();
        check("err_set", err, 1);
        do_start(4, 1);
        for (int i = 0; i < 4; i++) push(8'($urandom));
        check("err_sticky", err, 1);
        apply_reset();
        do_start(0, 1);
        check("err_bad_start_idle", busy, 0);
        check("err_bad_start", err, 1);
`endif

        // Randomized runs against the model.
        for (int run = 0; run < 30; run++) begin
            if (run % 5 == 0) apply_reset();
            if ($urandom_range(0, 7) == 0) do_start($urandom_range(17, 31), $urandom_range(0, 3));
            do_start($urandom_range(1, 16), $urandom_range(1, 6));
            guard = 0;
            while (m_busy && guard < 600) begin
                in_valid       = ($urandom_range(0, 3) != 0);
                in_data        = 8'($urandom);
                filter_release = ($urandom_range(0, 2) == 0);
                filter_raddr   = 4'($urandom);
                start          = ($urandom_range(0, 19) == 0);
                filter_size    = 5'($urandom_range(0, 20));
                num_filters    = 8'($urandom_range(0, 4));
                cycle();
                guard++;
            end
            start = 0; in_valid = 0; filter_release = 0;
            if (guard >= 600) begin
                checks++; errors++;
                $display("FAIL rand_timeout: run %0d still busy after %0d cycles, expected idle", run, guard);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filter_loader.md
Name: filter_loader

Overview:
- Upstream neighbour of the filter address generator in the CA4 convolution datapath.
- Accepts a stream of filter words through a valid/ready handshake and writes them into a circular filter scratchpad of HEIGHT words.
- Tracks how many complete filters are resident, and serves synchronous reads at the address produced by the generator.
- Frees one filter's worth of space each time the generator advances to the next filter.

Parameters:
- HEIGHT, 16, scratchpad depth in words; power of two, ≥ 2.
- WIDTH, 8, filter word width in bits.
- ADD_WIDTH, $clog2(HEIGHT), scratchpad address width.
- NUM_WIDTH, 8, width of the total-filter-count input.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- rst, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle pulse; latches filter_size and num_filters and begins loading.
- filter_size, input, ADD_WIDTH+1, words per filter.
- num_filters, input, NUM_WIDTH, total filters to load in this run.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, loader accepts a word this cycle.
- in_data, input, WIDTH, filter word.
- release, input, 1, one filter consumed; connects to the generator's filter_cnt_en.
- filter_raddr, input, ADD_WIDTH, read address from the generator.
- filter_rdata, output, WIDTH, scratchpad data.
- filter_avail, output, 1, at least one complete filter is resident.
- load_done, output, 1, all num_filters have been written.
- busy, output, 1, FSM is not IDLE.

Behaviour:
- Reset (rst = 0, asynchronous):
  - FSM goes to IDLE.
  - wptr, words_stored, filter_word_cnt, filter_count and loaded_cnt clear to 0.
  - in_ready, filter_avail, load_done and busy are 0.
  - filter_rdata is 0.
  - Scratchpad contents are not reset.
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on start when 1 ≤ filter_size ≤ HEIGHT and num_filters ≠ 0.
  - On this transition: latch fs and nf; clear all pointers and counters.
  - An invalid start is ignored and the FSM stays in IDLE.
- LOAD -> DONE in the cycle after the write that completes filter nf (loaded_cnt reaches nf).
- DONE -> IDLE when filter_count returns to 0 (all loaded filters released).
- start is ignored outside IDLE.
- Write rules:
  - in_ready = (state == LOAD) && (words_stored < HEIGHT) && (loaded_cnt < nf). Combinational; must not depend on in_valid.
  - A transfer occurs when in_valid && in_ready.
  - On a transfer: mem[wptr] <= in_data; wptr increments and wraps HEIGHT-1 -> 0; words_stored +1; filter_word_cnt +1.
  - When filter_word_cnt reaches fs-1 on a transfer: it resets to 0, filter_count +1 and loaded_cnt +1.
- Release rules:
  - release with filter_count ≠ 0: filter_count -1 and words_stored -fs.
  - release with filter_count == 0: ignored.
  - A transfer that completes a filter in the same cycle as a release: filter_count is unchanged and words_stored changes by +1-fs.
- Outputs:
  - filter_avail = (filter_count ≠ 0); registered state, visible the cycle after the completing write.
  - load_done = (state == DONE).
  - busy = (state ≠ IDLE).
- Read:
  - filter_rdata <= mem[filter_raddr] every cycle; 1-cycle latency.
  - Read and write to the same address in the same cycle return the old data.
- Arithmetic:
  - words_stored is ADD_WIDTH+1 bits and never exceeds HEIGHT.
  - All pointer arithmetic is modulo HEIGHT.
- Wrap-around: a filter may straddle the HEIGHT-1 -> 0 boundary. The generator's address arithmetic wraps identically because both use ADD_WIDTH-bit addresses.

Optional Feature:
- Macro: FILTER_LOADER_ERR_EN.
- When defined:
  - Adds output err (1 bit), sticky and cleared only by reset.
  - err is set by: release while filter_count == 0; start while not IDLE; or start with invalid filter_size/num_filters.
- When undefined: no err port, and these events are silently ignored as described above.

Decomposition:
- Shared package filter_pkg holds:
  - the state enum (IDLE, LOAD, DONE);
  - the default HEIGHT/WIDTH constants;
  - a clog2-based address-width helper, shared with the generator.
- One natural sub-module, filter_spad: HEIGHT x WIDTH memory with one synchronous write port and one registered read port.
- Pointers and counters reuse the existing Counter and Register blocks.

Test Plan:
- Basic load, HEIGHT=16: start with fs=4, nf=2; stream 8 words 0x10..0x17 -> filter_avail goes 1 the cycle after the 4th word; load_done 1 after the 8th; words_stored = 8.
- Backpressure: fs=8, nf=3, in_valid held high with no release -> in_ready drops after 16 words. One release -> in_ready returns and exactly 8 more words are accepted; load_done = 1.
- Wrap-around: fs=6, nf=4 with a release after each filter -> filter 3 occupies addresses 12..15 and 0..1. Reading raddr 0 returns filter 3's 5th word one cycle later.
- Simultaneous events: release in the same cycle as the write that completes a filter -> filter_count unchanged; words_stored = previous + 1 - fs.
- Reset mid-LOAD after 5 words -> all outputs 0 and state IDLE. A fresh start with fs=2, nf=1 then loads normally from address 0.
- With FILTER_LOADER_ERR_EN defined: release in IDLE -> err = 1 and stays 1 through the next start and load; start with fs=0 -> FSM stays in IDLE.
